// File: rtl/t02_pkg.sv
// Shared definitions for the Wishbone register-file subordinate.
//   state_t  : handshake FSM states (IDLE, WAIT, ACK, HOLD)
//   BAD_READ : data returned for a read outside the register window
//   CNT_W    : width of the wait-state counter
package t02_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [31:0] BAD_READ = 32'hBAD0_BAD0;
    localparam int          CNT_W    = 3;

endpackage

// File: rtl/t02_byte_merge.sv
// Byte-lane merge used for partial register writes.
// Ports:
//   old_word    : current register contents
//   new_word    : write data from the bus
//   sel         : byte enables, bit n selects bits [8n+7:8n] of new_word
//   merged_word : old_word with the selected bytes replaced by new_word
module t02_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  sel,
    output logic [31:0] merged_word
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign merged_word[8*gi +: 8] = sel[gi] ? new_word[8*gi +: 8]
                                                    : old_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/t02_wishbone_subordinate.sv
// Wishbone classic subordinate exposing NWORDS 32-bit registers at BASE_ADDR,
// with WAIT_STATES idle cycles before each acknowledge.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   CYC_I, STB_I, WE_I  : bus cycle, strobe and write enable
//   ADR_I, DAT_I, SEL_I : byte address, write data, byte enables
//   DAT_O, ACK_O        : read data (held until the next read), one-cycle ack
//   regs_o              : all registers flattened, word i at [32i+31:32i]
//   wr_pulse_o          : one-cycle pulse per committed in-range write
//   wr_idx_o            : index of the last committed write
module t02_wishbone_subordinate
    import t02_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          NWORDS      = 16,
    parameter int          WAIT_STATES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      CYC_I,
    input  logic                      STB_I,
    input  logic                      WE_I,
    input  logic [31:0]               ADR_I,
    input  logic [31:0]               DAT_I,
    input  logic [3:0]                SEL_I,
    output logic [31:0]               DAT_O,
    output logic                      ACK_O,
    output logic [NWORDS*32-1:0]      regs_o,
    output logic                      wr_pulse_o,
    output logic [$clog2(NWORDS)-1:0] wr_idx_o
);

    localparam int              IDX_W    = $clog2(NWORDS);
    localparam logic [CNT_W-1:0] WS      = CNT_W'(WAIT_STATES);
    // One past the last byte of the window; 33 bits so a window ending at the
    // top of the address space does not wrap.
    localparam logic [32:0]     END_EXCL = {1'b0, BASE_ADDR} + 33'(4 * NWORDS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        regs_q [NWORDS];
    logic [31:0]        regs_d [NWORDS];
    logic [31:0]        dat_o_q, dat_o_d;
    logic               ack_q, ack_d;
    logic               wr_pulse_q, wr_pulse_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;

    // With zero wait states the commit happens on the accepting edge, before
    // the request has been latched, so the live bus is used while in IDLE.
    logic               req_we;
    logic [31:0]        req_adr;
    logic [31:0]        req_dat;
    logic [3:0]         req_sel;
    logic               in_range;
    logic [IDX_W-1:0]   req_idx;
    logic [31:0]        merged;
    logic               enter_ack;

    always_comb begin
        if (state_q == IDLE) begin
            req_we  = WE_I;
            req_adr = ADR_I;
            req_dat = DAT_I;
            req_sel = SEL_I;
        end else begin
            req_we  = we_q;
            req_adr = adr_q;
            req_dat = dat_q;
            req_sel = sel_q;
        end
    end

    assign in_range = (req_adr >= BASE_ADDR) && ({1'b0, req_adr} < END_EXCL);
    // Word index; the byte offset bits [1:0] drop out with the shift.
    assign req_idx  = IDX_W'((req_adr - BASE_ADDR) >> 2);

    t02_byte_merge u_merge (
        .old_word    (regs_q[req_idx]),
        .new_word    (req_dat),
        .sel         (req_sel),
        .merged_word (merged)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        regs_d     = regs_q;
        dat_o_d    = dat_o_q;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx_q;
        enter_ack  = 1'b0;

        case (state_q)
            IDLE: begin
                if (CYC_I && STB_I) begin
                    we_d  = WE_I;
                    adr_d = ADR_I;
                    dat_d = DAT_I;
                    sel_d = SEL_I;
                    if (WS == '0) begin
                        enter_ack = 1'b1;
                    end else begin
                        cnt_d   = WS;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!CYC_I) begin
                    // Master abandoned the cycle: drop it without committing.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_W'(1)) begin
                    cnt_d     = '0;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = HOLD;
            end
            HOLD: begin
                // Wait for the strobe to drop so one request is acked once.
                if (!STB_I) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Writes commit and reads capture on the edge that enters ACK.
        if (enter_ack) begin
            state_d = ACK;
            if (req_we) begin
                if (in_range) begin
                    regs_d[req_idx] = merged;
                    wr_pulse_d      = 1'b1;
                    wr_idx_d        = req_idx;
                end
            end else begin
                dat_o_d = in_range ? regs_q[req_idx] : BAD_READ;
            end
        end

        ack_d = (state_d == ACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            dat_o_q    <= '0;
            ack_q      <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
            for (int i = 0; i < NWORDS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            dat_o_q    <= dat_o_d;
            ack_q      <= ack_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
            for (int i = 0; i < NWORDS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_regs_out
            assign regs_o[32*gi +: 32] = regs_q[gi];
        end
    endgenerate

    assign DAT_O      = dat_o_q;
    assign ACK_O      = ack_q;
    assign wr_pulse_o = wr_pulse_q;
    assign wr_idx_o   = wr_idx_q;

endmodule

// File: tb/tb_t02_wishbone_subordinate.sv
module tb_t02_wishbone_subordinate;

    localparam int NW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Three instances differing only in WAIT_STATES; each has its own CYC/STB.
    logic [2:0]          cyc = '0;
    logic [2:0]          stb = '0;
    logic                we  = 1'b0;
    logic [31:0]         adr = '0;
    logic [31:0]         wdat = '0;
    logic [3:0]          sel = '0;
    logic [31:0]         dat_o [3];
    logic [2:0]          ack;
    logic [NW*32-1:0]    regs [3];
    logic [2:0]          wrp;
    logic [3:0]          wri [3];

    int ws_of [3] = '{1, 3, 0};

    t02_wishbone_subordinate #(.BASE_ADDR(32'h3000_0000), .NWORDS(NW), .WAIT_STATES(1)) u_dut0 (
        .clk(clk), .rst(rst), .CYC_I(cyc[0]), .STB_I(stb[0]), .WE_I(we), .ADR_I(adr),
        .DAT_I(wdat), .SEL_I(sel), .DAT_O(dat_o[0]), .ACK_O(ack[0]), .regs_o(regs[0]),
        .wr_pulse_o(wrp[0]), .wr_idx_o(wri[0]));
    t02_wishbone_subordinate #(.BASE_ADDR(32'h3000_0000), .NWORDS(NW), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rst(rst), .CYC_I(cyc[1]), .STB_I(stb[1]), .WE_I(we), .ADR_I(adr),
        .DAT_I(wdat), .SEL_I(sel), .DAT_O(dat_o[1]), .ACK_O(ack[1]), .regs_o(regs[1]),
        .wr_pulse_o(wrp[1]), .wr_idx_o(wri[1]));
    t02_wishbone_subordinate #(.BASE_ADDR(32'h3000_0000), .NWORDS(NW), .WAIT_STATES(0)) u_dut2 (
        .clk(clk), .rst(rst), .CYC_I(cyc[2]), .STB_I(stb[2]), .WE_I(we), .ADR_I(adr),
        .DAT_I(wdat), .SEL_I(sel), .DAT_O(dat_o[2]), .ACK_O(ack[2]), .regs_o(regs[2]),
        .wr_pulse_o(wrp[2]), .wr_idx_o(wri[2]));

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [3][NW];
    logic [31:0] exp_q [$];
    int ack_cnt [3]   = '{0, 0, 0};
    int pulse_cnt [3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ack[d]) ack_cnt[d]++;
            if (wrp[d]) pulse_cnt[d]++;
        end
    end

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < NW; i++)
                mdl[d][i] = 32'h0;
    endtask

    // One bus transfer on instance d; starts and ends at a falling edge.
    // Reads push their expectation when driven and pop it at the acknowledge.
    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] data, input logic [3:0] s,
                        output int lat, output bit acked, output bit pulsed);
        bit in_r;
        int ix;
        logic [31:0] expd;
        in_r = (a >= 32'h3000_0000) && (a <= 32'h3000_003F);
        ix   = in_r ? int'((a - 32'h3000_0000) >> 2) : 0;
        if (!w) exp_q.push_back(in_r ? mdl[d][ix] : 32'hBAD0_BAD0);
        cyc[d] = 1'b1; stb[d] = 1'b1; we = w; adr = a; wdat = data; sel = s;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack[d] && lat < 20);
        acked  = ack[d];
        pulsed = wrp[d];
        if (!w) begin
            expd = exp_q.pop_front();
            if (acked) begin
                checks++;
                if (dat_o[d] !== expd) begin
                    errors++;
                    $display("FAIL read_data dut%0d adr=%08h: got %08h, expected %08h", d, a, dat_o[d], expd);
                end
            end
        end else if (acked && in_r) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[d][ix][8*b +: 8] = data[8*b +: 8];
        end
        $display("xfer dut%0d %s adr=%08h wdata=%08h sel=%h rdata=%08h lat=%0d ack=%0d pulse=%0d",
                 d, w ? "WR" : "RD", a, data, s, dat_o[d], lat, acked, pulsed);
        cyc[d] = 1'b0; stb[d] = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc = '0; stb = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ack[d] !== 1'b0) begin errors++; $display("FAIL reset_ack dut%0d: got %b, expected 0", d, ack[d]); end
            checks++;
            if (dat_o[d] !== 32'h0) begin errors++; $display("FAIL reset_dat dut%0d: got %08h, expected 0", d, dat_o[d]); end
            checks++;
            if (wrp[d] !== 1'b0) begin errors++; $display("FAIL reset_pulse dut%0d: got %b, expected 0", d, wrp[d]); end
            checks++;
            if (wri[d] !== 4'd0) begin errors++; $display("FAIL reset_idx dut%0d: got %0d, expected 0", d, wri[d]); end
            checks++;
            if (regs[d] !== '0) begin errors++; $display("FAIL reset_regs dut%0d: got nonzero, expected all 0", d); end
        end
    endtask

    task automatic test_read_latency();
        int lat; bit acked, pulsed;
        for (int d = 0; d < 3; d++) begin
            xfer(d, 1'b0, 32'h3000_0004, 32'h0, 4'hF, lat, acked, pulsed);
            checks++;
            if (lat != ws_of[d] + 1) begin
                errors++;
                $display("FAIL read_latency dut%0d: got %0d cycles, expected %0d", d, lat, ws_of[d] + 1);
            end
        end
    endtask

    task automatic test_write_merge();
        int lat; bit acked, pulsed;
        int p0;
        logic [31:0] dat_before;
        p0 = pulse_cnt[0];
        dat_before = dat_o[0];
        xfer(0, 1'b1, 32'h3000_0008, 32'hDEAD_BEEF, 4'hF, lat, acked, pulsed);
        checks++;
        if (!pulsed) begin errors++; $display("FAIL wr_pulse_full dut0: got 0, expected 1"); end
        xfer(0, 1'b1, 32'h3000_0008, 32'h0000_0011, 4'b0001, lat, acked, pulsed);
        #1;
        checks++;
        if (pulse_cnt[0] - p0 != 2) begin errors++; $display("FAIL wr_pulse_count dut0: got %0d, expected 2", pulse_cnt[0] - p0); end
        checks++;
        if (wri[0] !== 4'd2) begin errors++; $display("FAIL wr_idx dut0: got %0d, expected 2", wri[0]); end
        checks++;
        if (regs[0][95:64] !== 32'hDEAD_BE11) begin errors++; $display("FAIL regs_word2 dut0: got %08h, expected deadbe11", regs[0][95:64]); end
        checks++;
        if (dat_o[0] !== dat_before) begin errors++; $display("FAIL dat_hold dut0: got %08h, expected %08h", dat_o[0], dat_before); end
        xfer(0, 1'b0, 32'h3000_0008, 32'h0, 4'h0, lat, acked, pulsed);
    endtask

    task automatic test_out_of_range();
        int lat; bit acked, pulsed;
        logic [NW*32-1:0] snap;
        int p0;
        snap = regs[0];
        p0 = pulse_cnt[0];
        xfer(0, 1'b0, 32'h3000_0040, 32'h0, 4'hF, lat, acked, pulsed);
        checks++;
        if (!acked) begin errors++; $display("FAIL oor_read_ack dut0: got 0, expected 1"); end
        xfer(0, 1'b1, 32'h2FFF_FFFC, 32'hFFFF_FFFF, 4'hF, lat, acked, pulsed);
        checks++;
        if (!acked || pulsed) begin errors++; $display("FAIL oor_write dut0: ack=%0d pulse=%0d, expected ack=1 pulse=0", acked, pulsed); end
        #1;
        checks++;
        if (regs[0] !== snap || pulse_cnt[0] != p0) begin
            errors++; $display("FAIL oor_regs dut0: regs changed or pulses=%0d, expected unchanged and 0", pulse_cnt[0] - p0);
        end
        // Byte offset bits ignored: this reads word 2.
        xfer(0, 1'b0, 32'h3000_000B, 32'h0, 4'h0, lat, acked, pulsed);
        // Last word of the window, partial write.
        xfer(0, 1'b1, 32'h3000_003C, 32'hA1B2_C3D4, 4'b1010, lat, acked, pulsed);
        checks++;
        if (regs[0][511:480] !== 32'hA100_C300) begin errors++; $display("FAIL last_word dut0: got %08h, expected a100c300", regs[0][511:480]); end
        checks++;
        if (wri[0] !== 4'd15) begin errors++; $display("FAIL last_idx dut0: got %0d, expected 15", wri[0]); end
    endtask

    task automatic test_no_double_ack();
        int lat; bit acked, pulsed;
        int a0, k;
        logic [31:0] expd;
        a0 = ack_cnt[0];
        exp_q.push_back(mdl[0][2]);
        cyc[0] = 1'b1; stb[0] = 1'b1; we = 1'b0; adr = 32'h3000_0008; sel = 4'hF;
        @(posedge clk);
        k = 0;
        do begin @(negedge clk); k++; end while (!ack[0] && k < 20);
        expd = exp_q.pop_front();
        checks++;
        if (!ack[0] || dat_o[0] !== expd) begin
            errors++; $display("FAIL held_read dut0: ack=%0d data=%08h, expected ack=1 data=%08h", ack[0], dat_o[0], expd);
        end
        $display("xfer dut0 RD adr=30000008 held strobe rdata=%08h lat=%0d", dat_o[0], k);
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (ack_cnt[0] - a0 != 1) begin errors++; $display("FAIL double_ack dut0: got %0d acks, expected 1", ack_cnt[0] - a0); end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        xfer(0, 1'b0, 32'h3000_003C, 32'h0, 4'hF, lat, acked, pulsed);
        checks++;
        if (lat != 2) begin errors++; $display("FAIL next_after_hold dut0: got %0d cycles, expected 2", lat); end
    endtask

    task automatic test_abort();
        int lat; bit acked, pulsed;
        int a1, p1;
        a1 = ack_cnt[1];
        p1 = pulse_cnt[1];
        cyc[1] = 1'b1; stb[1] = 1'b1; we = 1'b1; adr = 32'h3000_0014; wdat = 32'hAAAA_5555; sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        $display("xfer dut1 WR adr=30000014 wdata=aaaa5555 aborted in wait");
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (ack_cnt[1] != a1) begin errors++; $display("FAIL abort_ack dut1: got %0d acks, expected 0", ack_cnt[1] - a1); end
        checks++;
        if (pulse_cnt[1] != p1) begin errors++; $display("FAIL abort_pulse dut1: got %0d pulses, expected 0", pulse_cnt[1] - p1); end
        checks++;
        if (regs[1][191:160] !== mdl[1][5]) begin errors++; $display("FAIL abort_reg dut1: got %08h, expected %08h", regs[1][191:160], mdl[1][5]); end
        @(negedge clk);
        xfer(1, 1'b0, 32'h3000_0014, 32'h0, 4'hF, lat, acked, pulsed);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL after_abort dut1: got %0d cycles, expected 4", lat); end
    endtask

    task automatic test_reset_in_flight();
        int lat; bit acked, pulsed;
        int a1, p1;
        a1 = ack_cnt[1];
        p1 = pulse_cnt[1];
        cyc[1] = 1'b1; stb[1] = 1'b1; we = 1'b1; adr = 32'h3000_0004; wdat = 32'h1234_5678; sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        $display("xfer dut1 WR adr=30000004 wdata=12345678 reset in wait");
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (regs[1][63:32] !== 32'h0) begin errors++; $display("FAIL rst_reg dut1: got %08h, expected 0", regs[1][63:32]); end
        checks++;
        if (ack_cnt[1] != a1 || pulse_cnt[1] != p1) begin
            errors++; $display("FAIL rst_pulses dut1: acks=%0d pulses=%0d, expected 0 0", ack_cnt[1] - a1, pulse_cnt[1] - p1);
        end
        checks++;
        if (regs[0] !== '0 || dat_o[0] !== 32'h0 || wri[0] !== 4'd0) begin
            errors++; $display("FAIL rst_outputs dut0: dat=%08h idx=%0d, expected 0 and regs 0", dat_o[0], wri[0]);
        end
        xfer(1, 1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF, lat, acked, pulsed);
        checks++;
        if (lat != 4 || !pulsed || wri[1] !== 4'd1) begin
            errors++; $display("FAIL post_rst_write dut1: lat=%0d pulse=%0d idx=%0d, expected 4 1 1", lat, pulsed, wri[1]);
        end
        checks++;
        if (regs[1][63:32] !== 32'h1234_5678) begin errors++; $display("FAIL post_rst_reg dut1: got %08h, expected 12345678", regs[1][63:32]); end
        xfer(1, 1'b0, 32'h3000_0004, 32'h0, 4'hF, lat, acked, pulsed);
    endtask

    task automatic test_back_to_back();
        int lat; bit acked, pulsed;
        logic [31:0] a, dv;
        logic [3:0] s;
        logic w;
        for (int n = 0; n < 16; n++) begin
            a  = 32'h3000_0000 + {$urandom_range(0, NW - 1), 2'b00} + 32'($urandom_range(0, 3));
            dv = $urandom;
            s  = 4'($urandom_range(0, 15));
            w  = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            xfer(2, w, a, dv, s, lat, acked, pulsed);
            checks++;
            if (lat != 1) begin errors++; $display("FAIL b2b_latency dut2 op%0d: got %0d cycles, expected 1", n, lat); end
        end
        #1;
        for (int i = 0; i < NW; i++) begin
            checks++;
            if (regs[2][32*i +: 32] !== mdl[2][i]) begin
                errors++; $display("FAIL b2b_regs dut2 word%0d: got %08h, expected %08h", i, regs[2][32*i +: 32], mdl[2][i]);
            end
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_read_latency();
        test_write_merge();
        test_out_of_range();
        test_no_double_ack();
        test_abort();
        test_reset_in_flight();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
